// File: rtl/spi_master_driver.sv
// SPI mode-0 initiator: streams words MSB-first on mosi while shifting miso in,
// and frames each transaction with ss setup, ss hold and a minimum ss-high gap.
module spi_master_driver #(
   parameter int WORD_WIDTH = 8,
   parameter int CLK_DIV    = 24,
   parameter int SS_DELAY   = 24
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic [WORD_WIDTH-1:0] tx_data,
   input  logic                  tx_last,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [WORD_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   input  logic                  miso_in,
   output logic                  sclk_out,
   output logic                  mosi_out,
   output logic                  ss_out
);

   localparam int MAX_AB = (CLK_DIV > SS_DELAY) ? CLK_DIV : SS_DELAY;
   localparam int MAX_V  = (MAX_AB > WORD_WIDTH) ? MAX_AB : WORD_WIDTH;
   localparam int CW     = $clog2(MAX_V + 1);

   localparam logic [CW-1:0] DIV_LOAD = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] SS_LOAD  = CW'(SS_DELAY - 1);
   localparam logic [CW-1:0] BIT_LOAD = CW'(WORD_WIDTH - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SS_SETUP   = 3'd1,
      ST_SHIFT_LOW  = 3'd2,
      ST_SHIFT_HIGH = 3'd3,
      ST_WORD_END   = 3'd4,
      ST_WAIT_NEXT  = 3'd5,
      ST_SS_HOLD    = 3'd6,
      ST_SS_GAP     = 3'd7
   } state_t;

   state_t                state_q;
   logic [CW-1:0]         cnt_q;
   logic [CW-1:0]         bit_q;
   logic [WORD_WIDTH-1:0] tx_sh_q;
   logic [WORD_WIDTH-2:0] rx_sh_q;
   logic                  last_q;
   logic [WORD_WIDTH-1:0] rx_data_q;
   logic                  rx_valid_q;
   logic                  busy_q;
   logic                  sclk_q;
   logic                  ss_q;

   logic [WORD_WIDTH-1:0] tx_shift_d;
   logic [WORD_WIDTH-1:0] rx_word_d;
   logic                  accept_s;

   // tx_ready is held low while reset is asserted even though state is IDLE
   assign tx_ready   = rst && ((state_q == ST_IDLE) || (state_q == ST_WAIT_NEXT));
   assign accept_s   = tx_valid && tx_ready;
   assign tx_shift_d = {tx_sh_q[WORD_WIDTH-2:0], 1'b0};
   assign rx_word_d  = {rx_sh_q, miso_in};

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = busy_q;
   assign sclk_out = sclk_q;
   assign mosi_out = tx_sh_q[WORD_WIDTH-1];
   assign ss_out   = ss_q;

   // Transaction FSM; every output register changes together with the state it belongs to
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= CNT_ZERO;
         bit_q      <= CNT_ZERO;
         tx_sh_q    <= {WORD_WIDTH{1'b0}};
         rx_sh_q    <= {(WORD_WIDTH-1){1'b0}};
         last_q     <= 1'b0;
         rx_data_q  <= {WORD_WIDTH{1'b0}};
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         sclk_q     <= 1'b0;
         ss_q       <= 1'b1;
      end else begin
         rx_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  tx_sh_q <= tx_data;
                  last_q  <= tx_last;
                  busy_q  <= 1'b1;
                  ss_q    <= 1'b0;
                  cnt_q   <= SS_LOAD;
                  state_q <= ST_SS_SETUP;
               end
            end
            ST_SS_SETUP: begin
               if (cnt_q != CNT_ZERO) begin
                  cnt_q <= cnt_q - CNT_ONE;
               end else begin
                  cnt_q   <= DIV_LOAD;
                  bit_q   <= BIT_LOAD;
                  state_q <= ST_SHIFT_LOW;
               end
            end
            ST_SHIFT_LOW: begin
               if (cnt_q != CNT_ZERO) begin
                  cnt_q <= cnt_q - CNT_ONE;
               end else begin
                  sclk_q  <= 1'b1;
                  cnt_q   <= DIV_LOAD;
                  state_q <= ST_SHIFT_HIGH;
               end
            end
            ST_SHIFT_HIGH: begin
               if (cnt_q != CNT_ZERO) begin
                  cnt_q <= cnt_q - CNT_ONE;
               end else begin
                  // miso is sampled as late as possible to absorb synchronizer delay
                  sclk_q  <= 1'b0;
                  rx_sh_q <= rx_word_d[WORD_WIDTH-2:0];
                  if (bit_q != CNT_ZERO) begin
                     bit_q   <= bit_q - CNT_ONE;
                     tx_sh_q <= tx_shift_d;
                     cnt_q   <= DIV_LOAD;
                     state_q <= ST_SHIFT_LOW;
                  end else begin
                     rx_data_q  <= rx_word_d;
                     rx_valid_q <= 1'b1;
                     state_q    <= ST_WORD_END;
                  end
               end
            end
            ST_WORD_END: begin
               if (last_q) begin
                  cnt_q   <= SS_LOAD;
                  state_q <= ST_SS_HOLD;
               end else begin
                  state_q <= ST_WAIT_NEXT;
               end
            end
            ST_WAIT_NEXT: begin
               if (accept_s) begin
                  tx_sh_q <= tx_data;
                  last_q  <= tx_last;
                  bit_q   <= BIT_LOAD;
                  cnt_q   <= DIV_LOAD;
                  state_q <= ST_SHIFT_LOW;
               end
            end
            ST_SS_HOLD: begin
               if (cnt_q != CNT_ZERO) begin
                  cnt_q <= cnt_q - CNT_ONE;
               end else begin
                  ss_q    <= 1'b1;
                  cnt_q   <= SS_LOAD;
                  state_q <= ST_SS_GAP;
               end
            end
            ST_SS_GAP: begin
               if (cnt_q != CNT_ZERO) begin
                  cnt_q <= cnt_q - CNT_ONE;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               ss_q    <= 1'b1;
               sclk_q  <= 1'b0;
               busy_q  <= 1'b0;
               cnt_q   <= CNT_ZERO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_driver.sv
// Self-checking bench for spi_master_driver: a slow instance driven by a mode-0
// target model, and a fast instance (CLK_DIV=1, SS_DELAY=1) in loopback.
module tb_spi_master_driver;

   localparam int DIV_A = 2;
   localparam int SS_A  = 3;
   localparam int DIV_B = 1;
   localparam int SS_B  = 1;

   logic       sys_clk = 1'b0;
   logic       rst     = 1'b0;

   logic [7:0] tx_data_a  = 8'h00;
   logic       tx_last_a  = 1'b0;
   logic       tx_valid_a = 1'b0;
   logic       tx_ready_a;
   logic [7:0] rx_data_a;
   logic       rx_valid_a, busy_a, miso_a, sclk_a, mosi_a, ss_a;

   logic [7:0] tx_data_b  = 8'h00;
   logic       tx_last_b  = 1'b0;
   logic       tx_valid_b = 1'b0;
   logic       tx_ready_b;
   logic [7:0] rx_data_b;
   logic       rx_valid_b, busy_b, miso_b, sclk_b, mosi_b, ss_b;

   int checks = 0;
   int errors = 0;

   always #5 sys_clk = ~sys_clk;

   spi_master_driver #(.WORD_WIDTH(8), .CLK_DIV(DIV_A), .SS_DELAY(SS_A)) dut_a (
      .sys_clk(sys_clk), .rst(rst), .tx_data(tx_data_a), .tx_last(tx_last_a),
      .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .rx_data(rx_data_a),
      .rx_valid(rx_valid_a), .busy(busy_a), .miso_in(miso_a), .sclk_out(sclk_a),
      .mosi_out(mosi_a), .ss_out(ss_a));

   spi_master_driver #(.WORD_WIDTH(8), .CLK_DIV(DIV_B), .SS_DELAY(SS_B)) dut_b (
      .sys_clk(sys_clk), .rst(rst), .tx_data(tx_data_b), .tx_last(tx_last_b),
      .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .rx_data(rx_data_b),
      .rx_valid(rx_valid_b), .busy(busy_b), .miso_in(miso_b), .sclk_out(sclk_b),
      .mosi_out(mosi_b), .ss_out(ss_b));

   assign miso_b = mosi_b;

   // Transaction words, target responses, and the target's serial bit stream
   logic [7:0]   txw[$];
   logic [7:0]   rsw[$];
   logic [127:0] resp_bits = 128'd0;
   logic [7:0]   bidx = 8'd0;

   assign miso_a = bidx[7] ? 1'b0 : resp_bits[bidx[6:0]];

   logic       mon_clr = 1'b0;
   int         cyc = 0;
   logic       p_sclk = 1'b0, p_ss = 1'b1, p_busy = 1'b0, p_rxv = 1'b0;
   int         hi_run = 0, ss_low_run = 0, ss_hi_run = 0;
   int         hi_bad = 0, dbl_rxv = 0, accepts = 0, ss_rise_cyc = 0, busy_fall_cyc = 0;
   logic       mosi_cap[$];
   logic [7:0] rx_cap[$];
   int         ss_low_len[$];
   int         ss_hi_len[$];

   // Bus monitor for dut_a, sampled on the falling sys_clk edge; the target shifts on sclk fall
   always @(negedge sys_clk) begin
      cyc++;
      if (mon_clr) begin
         hi_run = 0; ss_low_run = 0; ss_hi_run = 0; hi_bad = 0; dbl_rxv = 0;
         accepts = 0; ss_rise_cyc = 0; busy_fall_cyc = 0; bidx = 8'd0;
         mosi_cap.delete(); rx_cap.delete(); ss_low_len.delete(); ss_hi_len.delete();
         p_sclk = sclk_a; p_ss = ss_a; p_busy = busy_a; p_rxv = 1'b0;
      end else begin
         if (sclk_a && !p_sclk) begin
            mosi_cap.push_back(mosi_a);
            hi_run = 1;
         end else if (sclk_a) begin
            hi_run++;
         end else if (p_sclk) begin
            if (hi_run != DIV_A) hi_bad++;
            bidx = bidx + 8'd1;
         end
         if (!ss_a) begin
            if (p_ss && ss_low_len.size() > 0) ss_hi_len.push_back(ss_hi_run);
            ss_low_run++;
         end else if (!p_ss) begin
            ss_low_len.push_back(ss_low_run);
            ss_low_run = 0;
            ss_rise_cyc = cyc;
            ss_hi_run = 1;
         end else begin
            ss_hi_run++;
         end
         if (!busy_a && p_busy) busy_fall_cyc = cyc;
         if (rx_valid_a) begin
            rx_cap.push_back(rx_data_a);
            if (p_rxv) dbl_rxv++;
         end
         if (tx_valid_a && tx_ready_a) accepts++;
         p_sclk = sclk_a; p_ss = ss_a; p_busy = busy_a; p_rxv = rx_valid_a;
      end
   end

   function automatic int exp_low(input int n, input int gap);
      return 2 * SS_A + n * (2 * DIV_A * 8 + 1) + (n - 1) * (gap + 1);
   endfunction

   task automatic mon_clear();
      mon_clr = 1'b1;
      @(negedge sys_clk);
      #1;
      mon_clr = 1'b0;
   endtask

   task automatic set_resp(input int n);
      rsw.delete();
      for (int i = 0; i < n; i++) rsw.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic build_resp();
      resp_bits = 128'd0;
      for (int i = 0; i < rsw.size(); i++)
         for (int b = 0; b < 8; b++) resp_bits[i*8+b] = rsw[i][7-b];
   endtask

   task automatic wait_accept_a(output bit ok);
      logic rdy;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge sys_clk);
         rdy = tx_ready_a;
         @(posedge sys_clk);
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout: tx_ready never seen, required an accept");
      end
   endtask

   task automatic wait_rxv_a(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge sys_clk);
         if (rx_valid_a) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rxv_timeout: no rx_valid, required one");
      end
   endtask

   task automatic wait_idle_a();
      bit ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge sys_clk);
         if (!busy_a && tx_ready_a && ss_a) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL idle_timeout: busy=%0b ss=%0b, required idle", busy_a, ss_a);
      end
      @(negedge sys_clk);
   endtask

   // Send all words of txw; gap=0 keeps tx_valid high, else idle gap cycles in WAIT_NEXT
   task automatic run_words(input int gap);
      bit ok;
      int n = txw.size();
      build_resp();
      @(posedge sys_clk);
      #1;
      for (int w = 0; w < n; w++) begin
         tx_data_a  = txw[w];
         tx_last_a  = (w == n - 1);
         tx_valid_a = 1'b1;
         wait_accept_a(ok);
         if (!ok) break;
         if (gap > 0 && w < n - 1) begin
            tx_valid_a = 1'b0;
            wait_rxv_a(ok);
            if (!ok) break;
            for (int i = 0; i < gap; i++) begin
               @(negedge sys_clk);
               checks++;
               if ({tx_ready_a, ss_a, sclk_a, mosi_a} !== {1'b1, 1'b0, 1'b0, txw[w][0]}) begin
                  errors++;
                  $display("FAIL wait_next cyc%0d: ready/ss/sclk/mosi=%b required %b", i,
                           {tx_ready_a, ss_a, sclk_a, mosi_a}, {1'b1, 1'b0, 1'b0, txw[w][0]});
               end
            end
            @(posedge sys_clk);
            #1;
         end
      end
      tx_valid_a = 1'b0;
      wait_idle_a();
   endtask

   task automatic check_txn(input int n_ss, input int exp_ss_low);
      int n = txw.size();
      logic [7:0] wd;
      checks++;
      if (mosi_cap.size() != 8 * n) begin
         errors++;
         $display("FAIL sclk_rises: got %0d required %0d", mosi_cap.size(), 8 * n);
      end else begin
         for (int w = 0; w < n; w++) begin
            wd = 8'h00;
            for (int b = 0; b < 8; b++) wd = {wd[6:0], mosi_cap[w*8+b]};
            checks++;
            if (wd !== txw[w]) begin
               errors++;
               $display("FAIL mosi_word%0d: got %h required %h", w, wd, txw[w]);
            end
         end
      end
      checks++;
      if (rx_cap.size() != n) begin
         errors++;
         $display("FAIL rx_count: got %0d required %0d", rx_cap.size(), n);
      end else begin
         for (int w = 0; w < n; w++) begin
            checks++;
            if (rx_cap[w] !== rsw[w]) begin
               errors++;
               $display("FAIL rx_word%0d: got %h required %h", w, rx_cap[w], rsw[w]);
            end
         end
      end
      checks++;
      if (hi_bad != 0 || dbl_rxv != 0) begin
         errors++;
         $display("FAIL pulse_width: bad_high=%0d double_rxv=%0d required 0/0", hi_bad, dbl_rxv);
      end
      checks++;
      if (ss_low_len.size() != n_ss) begin
         errors++;
         $display("FAIL ss_frames: got %0d required %0d", ss_low_len.size(), n_ss);
      end else begin
         for (int i = 0; i < n_ss; i++) begin
            checks++;
            if (ss_low_len[i] != exp_ss_low) begin
               errors++;
               $display("FAIL ss_low_len%0d: got %0d required %0d", i, ss_low_len[i], exp_ss_low);
            end
         end
      end
      checks++;
      if (busy_fall_cyc - ss_rise_cyc != SS_A) begin
         errors++;
         $display("FAIL busy_tail: got %0d required %0d", busy_fall_cyc - ss_rise_cyc, SS_A);
      end
      checks++;
      if (accepts != n) begin
         errors++;
         $display("FAIL accepts: got %0d required %0d", accepts, n);
      end
      if (n_ss > 1) begin
         checks++;
         if (ss_hi_len.size() != n_ss - 1 || ss_hi_len[0] != SS_A + 1) begin
            errors++;
            $display("FAIL ss_gap: frames=%0d first=%0d required gap %0d", ss_hi_len.size(),
                     (ss_hi_len.size() > 0) ? ss_hi_len[0] : -1, SS_A + 1);
         end
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({ss_a, sclk_a, mosi_a, rx_valid_a, busy_a, tx_ready_a} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_ctrl: ss/sclk/mosi/rxv/busy/rdy=%b required 100000",
                  {ss_a, sclk_a, mosi_a, rx_valid_a, busy_a, tx_ready_a});
      end
      checks++;
      if (rx_data_a !== 8'h00) begin
         errors++;
         $display("FAIL reset_rx_data: got %h required 00", rx_data_a);
      end
      @(negedge sys_clk);
      rst = 1'b1;
      @(posedge sys_clk);
      #1;
      checks++;
      if (tx_ready_a !== 1'b1 || ss_a !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_ready: rdy=%b ss=%b required 1 1", tx_ready_a, ss_a);
      end
   endtask

   task automatic test_single_word();
      for (int k = 0; k < 3; k++) begin
         mon_clear();
         txw.delete();
         if (k == 0) begin
            txw.push_back(8'hA5);
            rsw.delete();
            rsw.push_back(8'h3C);
         end else begin
            txw.push_back(8'($urandom_range(0, 255)));
            set_resp(1);
         end
         run_words(0);
         check_txn(1, exp_low(1, 0));
      end
   endtask

   task automatic test_back_to_back();
      mon_clear();
      txw.delete();
      txw.push_back(8'h12);
      txw.push_back(8'h34);
      set_resp(2);
      run_words(0);
      check_txn(1, exp_low(2, 0));
      mon_clear();
      txw.delete();
      for (int i = 0; i < 3; i++) txw.push_back(8'($urandom_range(0, 255)));
      set_resp(3);
      run_words(0);
      check_txn(1, exp_low(3, 0));
   endtask

   task automatic test_delayed_word();
      mon_clear();
      txw.delete();
      for (int i = 0; i < 2; i++) txw.push_back(8'($urandom_range(0, 255)));
      set_resp(2);
      run_words(10);
      check_txn(1, exp_low(2, 10));
   endtask

   task automatic test_ignore_busy();
      bit ok;
      logic [7:0] w2 = 8'($urandom_range(0, 255));
      mon_clear();
      txw.delete();
      txw.push_back(8'($urandom_range(0, 255)));
      txw.push_back(w2);
      set_resp(2);
      build_resp();
      @(posedge sys_clk);
      #1;
      tx_data_a  = txw[0];
      tx_last_a  = 1'b1;
      tx_valid_a = 1'b1;
      wait_accept_a(ok);
      tx_data_a = w2;
      if (ok) wait_accept_a(ok);
      tx_valid_a = 1'b0;
      wait_idle_a();
      check_txn(2, exp_low(1, 0));
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen = 1'b0;
      mon_clear();
      txw.delete();
      txw.push_back(8'hFF);
      set_resp(1);
      build_resp();
      @(posedge sys_clk);
      #1;
      tx_data_a  = 8'hFF;
      tx_last_a  = 1'b1;
      tx_valid_a = 1'b1;
      wait_accept_a(ok);
      tx_valid_a = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge sys_clk);
         if (mosi_cap.size() >= 4) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL bit4_timeout: rises=%0d required 4", mosi_cap.size());
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({ss_a, sclk_a, mosi_a, rx_valid_a, busy_a, tx_ready_a} !== 6'b100000) begin
         errors++;
         $display("FAIL async_reset: ss/sclk/mosi/rxv/busy/rdy=%b required 100000",
                  {ss_a, sclk_a, mosi_a, rx_valid_a, busy_a, tx_ready_a});
      end
      repeat (3) @(negedge sys_clk);
      rst = 1'b1;
      checks++;
      if (rx_cap.size() != 0) begin
         errors++;
         $display("FAIL partial_word: rx pulses=%0d required 0", rx_cap.size());
      end
      @(posedge sys_clk);
      #1;
      checks++;
      if (tx_ready_a !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: got %b required 1", tx_ready_a);
      end
      mon_clear();
      txw.delete();
      txw.push_back(8'h81);
      set_resp(1);
      run_words(0);
      check_txn(1, exp_low(1, 0));
   endtask

   task automatic test_fast(input logic [7:0] w);
      logic seq[$];
      logic expq[$];
      logic bits[$];
      logic [7:0] rxw = 8'h00;
      logic [7:0] wd = 8'h00;
      logic p = 1'b0;
      logic rdy;
      int nrx = 0;
      int bad = 0;
      bit ok = 1'b0;
      bit started = 1'b0;
      bit done = 1'b0;
      @(posedge sys_clk);
      #1;
      tx_data_b  = w;
      tx_last_b  = 1'b1;
      tx_valid_b = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge sys_clk);
         rdy = tx_ready_b;
         @(posedge sys_clk);
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
      tx_valid_b = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge sys_clk);
         if (!ss_b) begin
            started = 1'b1;
            seq.push_back(sclk_b);
         end
         if (sclk_b && !p) bits.push_back(mosi_b);
         p = sclk_b;
         if (rx_valid_b) begin
            nrx++;
            rxw = rx_data_b;
         end
         if (started && ss_b) begin
            done = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok || !done) begin
         errors++;
         $display("FAIL fast_timeout: accepted=%0b framed=%0b required 1 1", ok, done);
      end
      for (int i = 0; i < SS_B; i++) expq.push_back(1'b0);
      for (int b = 0; b < 8; b++) begin
         for (int i = 0; i < DIV_B; i++) expq.push_back(1'b0);
         for (int i = 0; i < DIV_B; i++) expq.push_back(1'b1);
      end
      expq.push_back(1'b0);
      for (int i = 0; i < SS_B; i++) expq.push_back(1'b0);
      if (seq.size() != expq.size()) bad = 1;
      else for (int i = 0; i < seq.size(); i++) if (seq[i] !== expq[i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL fast_sclk_seq: len %0d mismatched %0d required len %0d", seq.size(), bad, expq.size());
      end
      checks++;
      if (bits.size() != 8) begin
         errors++;
         $display("FAIL fast_rises: got %0d required 8", bits.size());
      end else begin
         for (int b = 0; b < 8; b++) wd = {wd[6:0], bits[b]};
         checks++;
         if (wd !== w) begin
            errors++;
            $display("FAIL fast_mosi: got %h required %h", wd, w);
         end
      end
      checks++;
      if (nrx != 1 || rxw !== w) begin
         errors++;
         $display("FAIL fast_loopback: pulses=%0d rx=%h required 1 %h", nrx, rxw, w);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_delayed_word();
      test_ignore_busy();
      test_reset_mid();
      test_fast(8'h5A);
      test_fast(8'($urandom_range(0, 255)));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_master_driver.md
Name: spi_master_driver

Overview:
- SPI mode-0 initiator that lets the MITM control logic originate its own transactions toward the downstream SPI target, instead of only forwarding the host's bus.
- Generates sclk_out, ss_out and mosi_out from a streaming word interface and shifts in miso_in. miso_in is already synchronized upstream by the input synchronizer.
- Its outputs are muxed by the MITM control module onto the physical bus outputs.

Parameters:
- WORD_WIDTH, 8: bits per word, MSB first.
- CLK_DIV, 24: sys_clk cycles per sclk half-period. Must be >= 1. The default gives 1 MHz sclk at 48 MHz.
- SS_DELAY, 24: sys_clk cycles for each of: ss setup before the first edge, ss hold after the last edge, and minimum ss-high gap between transactions. Must be >= 1.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tx_data  in  WORD_WIDTH  word to transmit.
- tx_last  in  1  the word accepted with this flag ends the transaction (ss released after it).
- tx_valid  in  1  tx_data/tx_last valid.
- tx_ready  out  1  driver can accept a word this cycle.
- rx_data  out  WORD_WIDTH  last word received on miso.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- busy  out  1  a transaction is in progress.
- miso_in  in  1  synchronized target data.
- sclk_out  out  1  SPI clock, idle low.
- mosi_out  out  1  SPI data out.
- ss_out  out  1  slave select, active low.

Behaviour:
- Reset (rst=0, async):
  - Outputs: ss_out=1, sclk_out=0, mosi_out=0, rx_data=0, rx_valid=0, busy=0, tx_ready=0.
  - Internal: state=IDLE, all counters 0.
  - Applies immediately, including mid-transfer. No partial word is reported.
- Handshake:
  - A word is accepted on a sys_clk edge where tx_valid && tx_ready.
  - tx_data and tx_last are latched on acceptance.
  - tx_ready is 1 only in IDLE and WAIT_NEXT, and is combinational from state.
- IDLE:
  - tx_ready=1, busy=0, ss_out=1, sclk_out=0.
  - On accept: load shift register, latch last flag, busy=1, ss_out=0 from next cycle, go to SS_SETUP.
- SS_SETUP: hold SS_DELAY cycles, then SHIFT_LOW with bit counter = WORD_WIDTH-1.
- SHIFT_LOW:
  - sclk_out=0, mosi_out=shift[MSB].
  - Lasts CLK_DIV cycles, then SHIFT_HIGH.
- SHIFT_HIGH:
  - sclk_out=1, lasts CLK_DIV cycles.
  - On its final cycle, sample miso_in into the rx shift register LSB. Late sampling absorbs synchronizer latency.
  - If the bit counter > 0: decrement it, shift tx left, go to SHIFT_LOW.
  - Else: go to WORD_END.
- WORD_END (1 cycle):
  - sclk_out=0.
  - rx_data <= rx shift register, rx_valid=1 for exactly this cycle.
  - If last flag: go to SS_HOLD. Else: go to WAIT_NEXT.
- WAIT_NEXT:
  - tx_ready=1, ss_out=0, sclk_out=0, mosi_out holds the last bit.
  - Waits indefinitely.
  - On accept: load, go directly to SHIFT_LOW (no setup delay).
- SS_HOLD: SS_DELAY cycles with ss_out=0, then ss_out=1, go to SS_GAP.
- SS_GAP: SS_DELAY cycles, tx_ready=0, busy=1; then IDLE (busy=0).
- Timing:
  - Bit period = 2*CLK_DIV cycles.
  - Word = 2*CLK_DIV*WORD_WIDTH cycles, plus 1 for WORD_END.
  - Exactly WORD_WIDTH rising sclk edges per word. mosi is stable across every rising edge.
- Boundaries:
  - tx_valid outside IDLE/WAIT_NEXT is ignored (no accept).
  - tx_valid asserted in the same cycle as WORD_END is not accepted until the next cycle (WAIT_NEXT).
  - Counters are sized by clog2 of max(CLK_DIV, SS_DELAY, WORD_WIDTH)+1 and never wrap.

Test Plan:
- Single word (CLK_DIV=2, SS_DELAY=3): tx_data=0xA5, tx_last=1; target model returns 0x3C.
  -> ss_out low for 3+32+1+3 cycles.
  -> 8 sclk pulses, each 2 high/2 low.
  -> mosi at the rises = 1,0,1,0,0,1,0,1.
  -> rx_data=0x3C with a single-cycle rx_valid.
  -> busy drops 3 cycles after ss_out rises.
- Back-to-back words: 0x12 (last=0), then 0x34 (last=1) held valid.
  -> ss_out never rises between words; 16 sclk pulses.
  -> Second word starts the cycle after its accept; no setup delay.
  -> Two rx_valid pulses.
- Delayed second word (presented 10 cycles after WORD_END).
  -> tx_ready=1 and ss_out=0 throughout the wait.
  -> sclk_out stays 0, mosi holds; transfer then resumes correctly.
- tx_valid held high during SHIFT_LOW/HIGH and SS_GAP.
  -> tx_ready=0, nothing accepted, transmitted bits unchanged.
  -> The next accept occurs only on return to IDLE.
- Reset pulse during bit 4 of 0xFF.
  -> Outputs return to reset values asynchronously (ss_out=1, sclk_out=0, mosi_out=0); no rx_valid.
  -> After release: tx_ready=1 on the first clock; a new 0x81 transfers cleanly.
- CLK_DIV=1, SS_DELAY=1, 0x5A.
  -> sclk_out toggles every sys_clk; 8 rising edges.
  -> Bits 0,1,0,1,1,0,1,0 correct at each rise; loopback rx_data=0x5A.
